// File: rtl/lsu_pkg.sv
// lsu_pkg: op/state enums and address helpers shared by the LSU and its lane aligner.
package lsu_pkg;

   typedef enum logic [2:0] {LB = 3'd0, LBU, LH, LHU, LW, SB, SH, SW} op_e;
   typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_e;

   localparam int LANE_W = 8;

   function automatic int idx_w(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction

   function automatic logic [4:0] lane_lsb(input logic [1:0] off);
      return 5'(off) * 5'(LANE_W);
   endfunction

   function automatic logic is_load(input op_e op);
      return op <= LW;
   endfunction

   function automatic logic is_rmw(input op_e op);
      return op == SB || op == SH;
   endfunction

   function automatic logic is_half(input op_e op);
      return op == LH || op == LHU || op == SH;
   endfunction

   function automatic logic is_word(input op_e op);
      return op == LW || op == SW;
   endfunction

   function automatic logic misaligned(input op_e op, input logic [1:0] lo);
      return (is_half(op) && lo[0]) || (is_word(op) && lo != 2'b00);
   endfunction

   function automatic logic [31:0] align_down(input op_e op, input logic [31:0] a);
      return is_word(op) ? {a[31:2], 2'b00} : is_half(op) ? {a[31:1], 1'b0} : a;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian load extraction/extension and byte/halfword store merge.
module lsu_align
   import lsu_pkg::*;
(
   input  op_e         op,
   input  logic [1:0]  off,
   input  logic [31:0] rd_data,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   logic [4:0]  sa;
   logic [31:0] sh, mask, data;

   always_comb begin
      sa      = lane_lsb(off);
      sh      = rd_data >> sa;
      ld_data = op == LB  ? {{(32-LANE_W){sh[LANE_W-1]}}, sh[LANE_W-1:0]} :
                op == LBU ? {{(32-LANE_W){1'b0}}, sh[LANE_W-1:0]} :
                op == LH  ? {{(32-2*LANE_W){sh[2*LANE_W-1]}}, sh[2*LANE_W-1:0]} :
                op == LHU ? {{(32-2*LANE_W){1'b0}}, sh[2*LANE_W-1:0]} : rd_data;
      // replicate the store lane across the word, then keep only the addressed lane
      mask    = op == SB ? 32'h0000_00ff << sa : op == SH ? 32'h0000_ffff << sa : 32'hffff_ffff;
      data    = op == SB ? {4{wdata[7:0]}} : op == SH ? {2{wdata[15:0]}} : wdata;
      st_data = (rd_data & ~mask) | (data & mask);
   end

endmodule

// File: rtl/lsu.sv
// lsu: single-port load/store unit with read-modify-write sub-word stores.
// Define LSU_MISALIGN_EXC_EN to trap misaligned requests; otherwise they align down.
module lsu
   import lsu_pkg::*;
#(
   parameter int DEPTH = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_exc,
   output logic [31:0] dc_addr,
   output logic [31:0] dc_wr_data,
   input  logic [31:0] dc_rd_data,
   output logic        dc_wr_en
);

   localparam int IW = idx_w(DEPTH);

   state_e      state, state_n;
   op_e         op_in, r_op;
   logic [31:0] r_addr, r_wdata, merged, ld_data, st_data;
   logic        accept, mis, exc_pend, unused_addr;

   assign op_in       = op_e'(req_op);
   assign accept      = req_valid && req_ready;
   assign dc_addr     = {{(32-IW){1'b0}}, r_addr[IW+1:2]};
   assign unused_addr = ^r_addr[31:IW+2];

`ifdef LSU_MISALIGN_EXC_EN
   assign mis = misaligned(op_in, req_addr[1:0]);
`else
   assign mis = 1'b0;
`endif

   lsu_align u_align (
      .op      (r_op),
      .off     (r_addr[1:0]),
      .rd_data (dc_rd_data),
      .wdata   (r_wdata),
      .ld_data (ld_data),
      .st_data (st_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state == IDLE   ? (accept && !mis ? ACCESS : IDLE) :
                state == ACCESS ? (is_rmw(r_op) ? MERGE : IDLE) : IDLE;
   end

   always_comb begin
      req_ready  = state == IDLE;
      dc_wr_en   = !rst && ((state == ACCESS && r_op == SW) || state == MERGE);
      dc_wr_data = state == MERGE ? merged : r_wdata;
   end

   // misaligned requests never leave IDLE; exc_pend delays their response by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_exc   <= 1'b0;
         exc_pend   <= 1'b0;
         merged     <= '0;
         r_op       <= LB;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         resp_valid <= exc_pend || state == MERGE || (state == ACCESS && !is_rmw(r_op));
         resp_data  <= (state == ACCESS && is_load(r_op)) ? ld_data : '0;
         resp_exc   <= exc_pend;
         exc_pend   <= accept && mis;
         if (state == ACCESS) merged <= st_data;
         if (accept) begin
            r_op    <= op_in;
            r_addr  <= align_down(op_in, req_addr);
            r_wdata <= req_wdata;
         end
      end
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL have parameter DEPTH, default 128, giving the number of 32-bit words in the attached dcache.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  a CPU memory request is present.
REQ-005 req_ready  output  1  the LSU can accept a request; high iff the state is IDLE.
REQ-006 req_op  input  3  operation code: LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 resp_valid  output  1  one-cycle pulse marking request completion.
REQ-010 resp_data  output  32  load result, already extended; 0 for stores.
REQ-011 resp_exc  output  1  the request was misaligned; no dcache access was made.
REQ-012 dc_addr  output  32  word index sent to the dcache: byte address bits [31:2] masked to $clog2(DEPTH) bits, zero-extended.
REQ-013 dc_wr_data  output  32  full-word write data sent to the dcache.
REQ-014 dc_rd_data  input  32  combinational read data returned by the dcache for dc_addr.
REQ-015 dc_wr_en  output  1  word write strobe; the dcache commits the write on the next rising edge.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high; op, addr and wdata are registered at that edge.
REQ-017 The state machine SHALL have exactly these states: IDLE, ACCESS, MERGE.
REQ-018 State transitions SHALL be:
- IDLE to ACCESS on an aligned accept.
- ACCESS to IDLE for loads and SW.
- ACCESS to MERGE for SB and SH.
- MERGE to IDLE.
REQ-019 In ACCESS, loads SHALL select the addressed byte or halfword from dc_rd_data, sign-extend it for LB/LH and zero-extend it for LBU/LHU, register it into resp_data and pulse resp_valid; latency is 1 cycle after accept.
REQ-020 In ACCESS, SW SHALL drive dc_wr_en=1 and dc_wr_data=req_wdata, then pulse resp_valid with resp_data=0; latency is 1 cycle.
REQ-021 SB/SH (read-modify-write):
- In ACCESS, merge the low byte or halfword of wdata into dc_rd_data at the addressed lane and register the merged word.
- In MERGE, drive dc_wr_en=1 with the merged word, then pulse resp_valid.
- Latency is 2 cycles.
REQ-022 dc_wr_en SHALL be 0 in every state other than those in REQ-020/REQ-021, and SHALL be 0 in any cycle where rst is high.
REQ-023 resp_valid SHALL be high for exactly one cycle per request; there is no response backpressure.
REQ-024 req_ready SHALL be high in the same cycle as resp_valid, so back-to-back requests are allowed.
REQ-025 Misaligned requests are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0.
REQ-026 A misaligned request SHALL stay in IDLE, pulse resp_valid with resp_exc=1 and resp_data=0 one cycle after accept, and never assert dc_wr_en.
REQ-027 For aligned requests resp_exc SHALL be 0.
REQ-028 Byte and halfword lanes are little-endian: lane n occupies bits [8n+7:8n].

Reset
REQ-029 While rst is high at a rising edge the LSU SHALL:
- go to state IDLE;
- set resp_valid=0, resp_data=0 and resp_exc=0;
- clear all registered request fields.
REQ-030 Reset in ACCESS or MERGE SHALL abort the operation: no dcache write occurs and no resp_valid pulse is produced for the aborted request.

Configuration
REQ-031 With LSU_MISALIGN_EXC_EN defined, misalignment SHALL be handled per REQ-025 to REQ-027.
REQ-032 Without LSU_MISALIGN_EXC_EN:
- the offending low address bits are forced to 0 (the access aligns down);
- the access proceeds normally;
- resp_exc is tied to 0.

Structure
REQ-033 Package lsu_pkg SHALL hold the op enum (LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7), the state enum, and the helpers for word-index width and lane width.
REQ-034 Sub-module lsu_align (purely combinational) SHALL implement load extraction/extension and store merge; the LSU instantiates it once.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Word 5 = 0x8012_34F0; LB 0x14 -> 0xFFFF_FFF0; LBU 0x15 -> 0x0000_0034; LH 0x16 -> 0xFFFF_8012; each resp_valid 1 cycle after accept.
- SW 0x20 data 0xDEAD_BEEF -> dc_wr_en for exactly 1 cycle at dc_addr 8; a following LW 0x20 returns 0xDEAD_BEEF.
- Word 3 = 0x1122_3344; SB 0x0D data 0xAB -> a single write of 0x1122_AB44 in MERGE, resp_valid 2 cycles after accept; SH 0x0E data 0xCAFE -> 0xCAFE_AB44.
- LW 0x21 with the macro defined -> resp_exc=1, resp_data=0, no dc_wr_en; without the macro -> returns word 8, resp_exc=0.
- rst asserted during the MERGE of SB 0x0D -> no write (word 3 unchanged), no resp_valid, req_ready=1 the next cycle.
- Back-to-back: a new LW accepted in the resp_valid cycle of a prior SW -> both respond, in order.
